branch_flush_controller: RTL and testbench

Sequential control-flow sequencer for the 5-stage pipeline. It detects a branch or jump in decode, stalls fetch until execute resolves it, issues a one-cycle PC redirect on a taken outcome, and then releases the pipeline. It replaces a multi-stage combinational opcode scan with a single tracked in-flight control instruction. It also keeps saturating branch/taken statistics counters.

---
 rtl/branch_flush_controller.sv | 125 ++++++++++++
 tb/tb_branch_flush_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_flush_controller.sv
// branch_flush_controller: tracks one in-flight control instruction from decode
// to execute resolution. It stalls fetch while the instruction is unresolved,
// issues a one-cycle PC redirect on a taken outcome, and counts branches and
// taken resolutions with saturating counters.
module branch_flush_controller #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_decode,
    input  logic        id_valid,
    input  logic        data_stall,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    input  logic [15:0] ex_target,
    output logic        fetch_stall,
    output logic        id_bubble,
    output logic        pc_redirect,
    output logic [15:0] pc_target,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] branch_count,
    output logic [15:0] taken_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic [4:0]  opcode;
    logic        is_ctrl;
    logic        detect;
    logic        accept;
    logic        take;
    logic        expire;
    logic        unused_bits;

    // Branches occupy opcodes 011xx and jumps 001xx, so the top three bits
    // are enough to recognise the whole control set.
    assign opcode      = instr_decode[15:11];
    assign is_ctrl     = (opcode[4:2] == 3'b011) || (opcode[4:2] == 3'b001);
    assign detect      = id_valid && !data_stall && is_ctrl;
    assign unused_bits = ^instr_decode[10:0];

    // A resolve in the last WAIT cycle wins over the timeout.
    assign accept = (state == ST_IDLE) && detect;
    assign take   = (state == ST_WAIT) && ex_resolve && ex_taken;
    assign expire = (state == ST_WAIT) && !ex_resolve && (wait_cnt == WAIT_LAST);

    // Next-state and pipeline control; fetch_stall is forced low during reset
    // because in IDLE it follows the decode inputs.
    always_comb begin
        state_nxt   = state;
        fetch_stall = 1'b0;
        id_bubble   = 1'b0;
        pc_redirect = 1'b0;
        case (state)
            ST_IDLE: begin
                fetch_stall = detect && rst_n;
                if (detect) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                fetch_stall = 1'b1;
                id_bubble   = 1'b1;
                if (ex_resolve) state_nxt = ex_taken ? ST_REDIRECT : ST_IDLE;
                else if (wait_cnt == WAIT_LAST) state_nxt = ST_IDLE;
            end
            ST_REDIRECT: begin
                fetch_stall = 1'b1;
                id_bubble   = 1'b1;
                pc_redirect = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; busy is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    // Cycles spent in WAIT for the current control instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wait_cnt <= 4'd0;
        else if (accept)           wait_cnt <= 4'd0;
        else if (state == ST_WAIT) wait_cnt <= wait_cnt + 4'd1;
    end

    // Redirect target captured from EX on a taken resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pc_target <= 16'h0000;
        else if (take) pc_target <= ex_target;
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count <= 16'h0000;
            taken_count  <= 16'h0000;
        end else begin
            if (accept && branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
            if (take && taken_count != 16'hFFFF)    taken_count  <= taken_count + 16'd1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      timeout_err <= 1'b0;
        else if (expire) timeout_err <= 1'b1;
    end

endmodule

// File: tb/tb_branch_flush_controller.sv
// Directed bench for branch_flush_controller with hand-computed expectations.
module tb_branch_flush_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_decode;
    logic        id_valid;
    logic        data_stall;
    logic        ex_resolve;
    logic        ex_taken;
    logic [15:0] ex_target;
    logic        fetch_stall;
    logic        id_bubble;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic        busy;
    logic        timeout_err;
    logic [15:0] branch_count;
    logic [15:0] taken_count;

    int n_chk  = 0;
    int n_fail = 0;

    branch_flush_controller #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_decode (instr_decode),
        .id_valid     (id_valid),
        .data_stall   (data_stall),
        .ex_resolve   (ex_resolve),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .fetch_stall  (fetch_stall),
        .id_bubble    (id_bubble),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .branch_count (branch_count),
        .taken_count  (taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept a control instruction and resolve it not-taken in the first WAIT cycle.
    task automatic branch_nt(input logic [15:0] ins);
        instr_decode = ins; id_valid = 1'b1;
        cyc();
        id_valid = 1'b0; ex_resolve = 1'b1; ex_taken = 1'b0;
        cyc();
        ex_resolve = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; instr_decode = 16'h0000; id_valid = 1'b0; data_stall = 1'b0;
        ex_resolve = 1'b0; ex_taken = 1'b0; ex_target = 16'h0000;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_bcnt", branch_count, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Taken BEQZ: stall cycles 0-2, redirect in cycle 2, release in cycle 3.
        instr_decode = 16'h6000; id_valid = 1'b1;
        #1;
        chk("beqz_c0_stall", fetch_stall, 1);
        chk("beqz_c0_bubble", id_bubble, 0);
        chk("beqz_c0_busy", busy, 0);
        cyc();
        id_valid = 1'b0; ex_resolve = 1'b1; ex_taken = 1'b1; ex_target = 16'h0040;
        #1;
        chk("beqz_c1_stall", fetch_stall, 1);
        chk("beqz_c1_bubble", id_bubble, 1);
        chk("beqz_c1_busy", busy, 1);
        chk("beqz_c1_redir", pc_redirect, 0);
        chk("beqz_bcnt", branch_count, 1);
        cyc();
        ex_resolve = 1'b0; ex_taken = 1'b0;
        #1;
        chk("beqz_c2_redir", pc_redirect, 1);
        chk("beqz_c2_target", pc_target, 16'h0040);
        chk("beqz_c2_stall", fetch_stall, 1);
        chk("beqz_tcnt", taken_count, 1);
        cyc();
        #1;
        chk("beqz_c3_stall", fetch_stall, 0);
        chk("beqz_c3_redir", pc_redirect, 0);
        chk("beqz_c3_busy", busy, 0);

        // Not-taken BNEZ, then a J detected in the very cycle IDLE returns.
        instr_decode = 16'h6800; id_valid = 1'b1;
        #1;
        chk("bnez_c0_stall", fetch_stall, 1);
        cyc();
        id_valid = 1'b0; ex_resolve = 1'b1; ex_taken = 1'b0;
        #1;
        chk("bnez_c1_redir", pc_redirect, 0);
        cyc();
        ex_resolve = 1'b0;
        #1;
        chk("bnez_c2_stall", fetch_stall, 0);
        chk("bnez_c2_redir", pc_redirect, 0);
        chk("bnez_c2_busy", busy, 0);
        chk("bnez_tcnt", taken_count, 1);
        chk("bnez_bcnt", branch_count, 2);
        instr_decode = 16'h2000; id_valid = 1'b1;
        #1;
        chk("b2b_stall", fetch_stall, 1);
        cyc();
        id_valid = 1'b0; ex_resolve = 1'b1; ex_taken = 1'b1; ex_target = 16'h0100;
        #1;
        chk("b2b_busy", busy, 1);
        cyc();
        ex_resolve = 1'b0; ex_taken = 1'b0;
        #1;
        chk("b2b_redir", pc_redirect, 1);
        chk("b2b_target", pc_target, 16'h0100);
        cyc();
        chk("b2b_bcnt", branch_count, 3);
        chk("b2b_tcnt", taken_count, 2);

        // Gating: data_stall, non-control opcode, bubble.
        instr_decode = 16'h6000; id_valid = 1'b1; data_stall = 1'b1;
        #1;
        chk("gate_dstall_stall", fetch_stall, 0);
        cyc();
        chk("gate_dstall_busy", busy, 0);
        data_stall = 1'b0; instr_decode = 16'hD800;
        #1;
        chk("gate_add_stall", fetch_stall, 0);
        cyc();
        chk("gate_add_busy", busy, 0);
        instr_decode = 16'h6000; id_valid = 1'b0;
        #1;
        chk("gate_inv_stall", fetch_stall, 0);
        cyc();
        chk("gate_inv_busy", busy, 0);
        chk("gate_bcnt", branch_count, 3);

        // Resolve on the timeout boundary (4th WAIT cycle) wins.
        instr_decode = 16'h7000; id_valid = 1'b1;
        cyc();
        id_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        ex_resolve = 1'b1; ex_taken = 1'b1; ex_target = 16'h0200;
        #1;
        chk("bound_busy", busy, 1);
        cyc();
        ex_resolve = 1'b0; ex_taken = 1'b0;
        #1;
        chk("bound_redir", pc_redirect, 1);
        chk("bound_target", pc_target, 16'h0200);
        chk("bound_tmo", timeout_err, 0);
        cyc();
        chk("bound_idle", busy, 0);
        chk("bound_tcnt", taken_count, 3);

        // Timeout: JR never resolves; back in IDLE after 4 WAIT cycles.
        instr_decode = 16'h2800; id_valid = 1'b1;
        cyc();
        id_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_wait_busy", busy, 1);
            cyc();
        end
        #1;
        chk("tmo_busy", busy, 0);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_redir", pc_redirect, 0);
        branch_nt(16'h6000);
        #1;
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_bcnt", branch_count, 6);

        // Asynchronous reset mid-WAIT clears everything before the next edge.
        instr_decode = 16'h6000; id_valid = 1'b1;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", fetch_stall, 0);
        chk("arst_bubble", id_bubble, 0);
        chk("arst_redir", pc_redirect, 0);
        chk("arst_busy", busy, 0);
        chk("arst_target", pc_target, 0);
        chk("arst_tmo", timeout_err, 0);
        chk("arst_bcnt", branch_count, 0);
        chk("arst_tcnt", taken_count, 0);
        cyc();
        id_valid = 1'b0; rst_n = 1'b1;
        cyc();
        #1;
        chk("arst_rel_busy", busy, 0);
        chk("arst_rel_redir", pc_redirect, 0);
        chk("arst_rel_bcnt", branch_count, 0);

        // Saturation: start the counter near the top instead of running 65535 branches.
        force dut.branch_count = 16'hFFFD;
        #1;
        release dut.branch_count;
        branch_nt(16'h3000);
        chk("sat_fffe", branch_count, 16'hFFFE);
        branch_nt(16'h3800);
        chk("sat_ffff", branch_count, 16'hFFFF);
        branch_nt(16'h7800);
        chk("sat_hold", branch_count, 16'hFFFF);
        chk("sat_tcnt", taken_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
